// File: rtl/bram_fifo_pkg.sv
// Shared sizing helpers for the block-RAM FIFO controller.
package bram_fifo_pkg;

    localparam int unsigned AF_OFFSET_DEFAULT = 4;
    localparam int unsigned AE_LEVEL_DEFAULT  = 4;

    // Number of FIFO entries addressed by aw RAM address bits.
    function automatic int unsigned depth(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int unsigned count_width(input int unsigned aw);
        return aw + 32'(1);
    endfunction

endpackage

// File: rtl/bram_fifo_ptr.sv
// RAM address pointer: increments on request and wraps naturally at 2**ADDR_WIDTH.
module bram_fifo_ptr #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller driving an external simple dual-port RAM with 1-cycle registered read.
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_LEVEL_FLAGS_EN.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_LEVEL   = depth(ADDR_WIDTH) - AF_OFFSET_DEFAULT,
    parameter int unsigned AE_LEVEL   = AE_LEVEL_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic                                 full,
    input  logic                                 rd_en,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_valid,
    output logic                                 empty,
    output logic [count_width(ADDR_WIDTH)-1:0]   count,
`ifdef FIFO_LEVEL_FLAGS_EN
    output logic                                 almost_full,
    output logic                                 almost_empty,
`endif
    output logic                                 overflow,
    output logic                                 underflow,
    output logic                                 ram_we,
    output logic [ADDR_WIDTH-1:0]                ram_waddr,
    output logic [DATA_WIDTH-1:0]                ram_wdata,
    output logic [ADDR_WIDTH-1:0]                ram_raddr,
    input  logic [DATA_WIDTH-1:0]                ram_rdata
);

    localparam int unsigned DEPTH = depth(ADDR_WIDTH);
    localparam int unsigned CW    = count_width(ADDR_WIDTH);

    if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_level_check
        $error("bram_fifo_ctrl: AF_LEVEL/AE_LEVEL exceed FIFO depth");
    end

    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_nxt;

    // Flags come straight from the registered count; no same-cycle bypass.
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == CW'(0));
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    bram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    bram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    // RAM ports; a push while empty never pops, so read/write never collide on one address.
    assign ram_we    = wr_acc;
    assign ram_waddr = wr_ptr;
    assign ram_wdata = wr_data;
    assign ram_raddr = rd_ptr;
    assign rd_data   = ram_rdata;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count    <= count_nxt;
            rd_valid <= rd_acc;
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_LEVEL_FLAGS_EN
    // Level flags track the post-edge occupancy so they align with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_bram_fifo_ctrl;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
`ifdef FIFO_LEVEL_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    always #5 clk = ~clk;

    bram_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .count        (count),
`ifdef FIFO_LEVEL_FLAGS_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .overflow     (overflow),
        .underflow    (underflow),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata)
    );

    // Simple dual-port RAM, registered read every edge.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus push/pop totals for addressing.
    logic [DW-1:0] q[$];
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_ovf;
    bit            m_unf;
    int            m_pushes;
    int            m_pops;

    always @(posedge clk) begin
        bit is_full;
        bit is_empty;
        is_full  = (q.size() == DEPTH);
        is_empty = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_pushes = 0;
            m_pops   = 0;
        end else begin
            m_valid = rd_en && !is_empty;
            if (m_valid) begin
                m_data = q.pop_front();
                m_pops++;
            end
            if (wr_en && !is_full) begin
                q.push_back(wr_data);
                m_pushes++;
            end
            if (wr_en && is_full) m_ovf = 1'b1;
            if (rd_en && is_empty) m_unf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("rd_valid", 32'(rd_valid), 32'(m_valid));
            if (m_valid) chk("rd_data", 32'(rd_data), 32'(m_data));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            chk("ram_we", 32'(ram_we), 32'(wr_en && !rst && q.size() < DEPTH));
            chk("ram_waddr", 32'(ram_waddr), 32'(m_pushes % DEPTH));
            chk("ram_raddr", 32'(ram_raddr), 32'(m_pops % DEPTH));
            if (ram_we) chk("ram_wdata", 32'(ram_wdata), 32'(wr_data));
`ifdef FIFO_LEVEL_FLAGS_EN
            chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
            chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
`endif
        end
    end

    // Apply one cycle of inputs, then return to idle #1 after the consuming edge.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        checking = 1'b1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: idle after reset
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_full", 32'(full), 32'd0);
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_rd_valid", 32'(rd_valid), 32'd0);
        chk("t1_ram_we", 32'(ram_we), 32'd0);

        // 2: three pushes then three back-to-back pops
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        chk("t2_count", 32'(count), 32'd3);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t2_v0", 32'(rd_valid), 32'd1);
        chk("t2_d0", 32'(rd_data), 32'h11);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t2_d1", 32'(rd_data), 32'h22);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t2_d2", 32'(rd_data), 32'h33);
        chk("t2_empty", 32'(empty), 32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t2_v_end", 32'(rd_valid), 32'd0);

        // 3: fill, overflow, drain
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count", 32'(count), 32'd8);
        cycle(1'b1, 8'hFF, 1'b0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_count_ovf", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("t3_pop", 32'(rd_data), 32'hA0 + 32'(i));
        end
        chk("t3_empty", 32'(empty), 32'd1);

        // 4: steady-state push+pop across pointer wrap
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'hC0 + 8'(i), 1'b1);
            chk("t4_count", 32'(count), 32'd4);
            chk("t4_data", 32'(rd_data), (i < 4) ? 32'hB0 + 32'(i) : 32'hC0 + 32'(i - 4));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("t4_drain", 32'(rd_data), 32'hD0 + 32'(i));
        end

        // 5: underflow and push+pop while empty
        cycle(1'b0, 8'h00, 1'b1);
        chk("t5_no_valid", 32'(rd_valid), 32'd0);
        chk("t5_underflow", 32'(underflow), 32'd1);
        cycle(1'b1, 8'h5A, 1'b1);
        chk("t5_count", 32'(count), 32'd1);
        chk("t5_no_valid2", 32'(rd_valid), 32'd0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t5_valid", 32'(rd_valid), 32'd1);
        chk("t5_data", 32'(rd_data), 32'h5A);

        // 6: reset mid-stream with a pop request
        do_reset();
        chk("t6_sticky_clr", 32'({overflow, underflow}), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
        chk("t6_count5", 32'(count), 32'd5);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_no_valid", 32'(rd_valid), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t6_no_valid2", 32'(rd_valid), 32'd0);

`ifdef FIFO_LEVEL_FLAGS_EN
        chk("t6_ae_rst", 32'(almost_empty), 32'd1);
        chk("t6_af_rst", 32'(almost_full), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b1, 8'h70 + 8'(i), 1'b0);
            chk("t6_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            chk("t6_ae", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
        end
`endif

        cycle(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
